// File: rtl/mdc_pkg.sv
// Shared types and decode helpers for the MDC determinant sequencer.
// Build option MDC_HAMMING_EN widens the mode word to a 9-bit Hamming(9,5) codeword.
package mdc_pkg;

`ifdef MDC_HAMMING_EN
  localparam int MODE_W = 9;
`else
  localparam int MODE_W = 5;
`endif

  localparam int         N_ELEM   = 16;
  localparam logic [4:0] MODE_2X2 = 5'b00100;
  localparam logic [4:0] MODE_3X3 = 5'b00110;
  localparam logic [4:0] MODE_4X4 = 5'b10110;

  typedef enum logic [1:0] {
    M_2X2 = 2'd0,
    M_3X3 = 2'd1,
    M_4X4 = 2'd2,
    M_ILL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } ctrl_state_e;

  function automatic mode_e mode_decode(input logic [4:0] code);
    mode_e m;
    case (code)
      MODE_2X2: m = M_2X2;
      MODE_3X3: m = M_3X3;
      MODE_4X4: m = M_4X4;
      default:  m = M_ILL;
    endcase
    return m;
  endfunction

  // Terms per det minus one: 1 / 3 / 4.
  function automatic logic [1:0] n_terms_m1(input mode_e m);
    logic [1:0] n;
    case (m)
      M_3X3:   n = 2'd2;
      M_4X4:   n = 2'd3;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Dets per matrix minus one: 9 / 4 / 1.
  function automatic logic [3:0] n_dets_m1(input mode_e m);
    logic [3:0] n;
    case (m)
      M_2X2:   n = 4'd8;
      M_3X3:   n = 4'd3;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  // Element count at which det's operands have all been written.
  function automatic logic [4:0] elig_thr(input mode_e m, input logic [3:0] det);
    logic [4:0] thr;
    case (m)
      M_2X2:   thr = 5'd6 + 5'(4 * (32'(det) / 3)) + 5'(32'(det) % 3);
      M_3X3:   thr = 5'd11 + {2'b00, det[1], 1'b0, det[0]};
      default: thr = 5'd16;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/mdc_sched_ctrl_if.sv
// Element-stream, write-port, issue and result signals of the MDC sequencer.
interface mdc_sched_ctrl_if;
  logic                      in_valid;
  logic [mdc_pkg::MODE_W-1:0] in_mode;
  logic                      busy;
  logic                      wr_en;
  logic [3:0]                wr_addr;
  logic                      iss_valid;
  logic [1:0]                iss_mode;
  logic [3:0]                iss_det;
  logic [1:0]                iss_term;
  logic                      iss_last;
  logic                      out_valid;
  logic                      out_err;

  modport master (
    output in_valid, in_mode,
    input  busy, wr_en, wr_addr, iss_valid, iss_mode, iss_det, iss_term, iss_last,
           out_valid, out_err
  );

  modport slave (
    input  in_valid, in_mode,
    output busy, wr_en, wr_addr, iss_valid, iss_mode, iss_det, iss_term, iss_last,
           out_valid, out_err
  );
endinterface

// File: rtl/mdc_ham_dec.sv
// Hamming(9,5) single-error-correcting decoder. Bit i holds codeword position i+1:
// p1 p2 d0 p4 d1 d2 d3 p8 d4. Syndromes 10..15 cannot come from one flip and flag o_err.
module mdc_ham_dec (
  input  logic [8:0] i_code,
  output logic [4:0] o_data,
  output logic       o_err
);
  logic [3:0] w_syn;
  logic [8:0] w_flip;
  logic [8:0] w_fix;

  assign w_syn[0] = i_code[0] ^ i_code[2] ^ i_code[4] ^ i_code[6] ^ i_code[8];
  assign w_syn[1] = i_code[1] ^ i_code[2] ^ i_code[5] ^ i_code[6];
  assign w_syn[2] = i_code[3] ^ i_code[4] ^ i_code[5] ^ i_code[6];
  assign w_syn[3] = i_code[7] ^ i_code[8];

  assign o_err  = (w_syn > 4'd9);
  assign w_flip = (w_syn != 4'd0 && !o_err) ? (9'd1 << (w_syn - 4'd1)) : 9'd0;
  assign w_fix  = i_code ^ w_flip;
  assign o_data = {w_fix[8], w_fix[6], w_fix[5], w_fix[4], w_fix[2]};
endmodule

// File: rtl/mdc_sched_ctrl.sv
// MDC determinant sequencer: counts the element stream, issues (det, term) jobs as operands
// arrive, and strobes the result after the pipe drains. MDC_HAMMING_EN selects a Hamming mode word.
module mdc_sched_ctrl
  import mdc_pkg::*;
#(
  parameter int PIPE_LAT = 3
) (
  input logic         clk,
  input logic         rst_n,
  mdc_sched_ctrl_if.slave bus
);
  localparam int DW = $clog2(PIPE_LAT + 2);

  ctrl_state_e   r_state;
  mode_e         r_mode;
  logic [4:0]    r_cnt;
  logic [3:0]    r_det;
  logic [1:0]    r_term;
  logic [DW-1:0] r_dcnt;
  logic          r_out_vld;
  logic          r_out_err;

  logic [4:0] w_raw;
  logic       w_code_err;
  mode_e      w_mode_in;
  logic       w_wr;
  logic       w_iss;
  logic       w_last;
  logic       w_done;

`ifdef MDC_HAMMING_EN
  mdc_ham_dec u_dec (
    .i_code (bus.in_mode),
    .o_data (w_raw),
    .o_err  (w_code_err)
  );
`else
  assign w_raw      = bus.in_mode;
  assign w_code_err = 1'b0;
`endif

  assign w_mode_in = w_code_err ? M_ILL : mode_decode(w_raw);

  // Elements past the 16th are not part of this matrix and are dropped.
  assign w_wr   = bus.in_valid && (r_state == S_IDLE || r_state == S_LOAD) && (r_cnt < 5'(N_ELEM));
  assign w_iss  = (r_state == S_LOAD) && (r_mode != M_ILL) && (r_cnt >= elig_thr(r_mode, r_det));
  assign w_last = w_iss && (r_term == n_terms_m1(r_mode));
  assign w_done = w_last && (r_det == n_dets_m1(r_mode));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mode    <= M_2X2;
      r_cnt     <= '0;
      r_det     <= '0;
      r_term    <= '0;
      r_dcnt    <= '0;
      r_out_vld <= 1'b0;
      r_out_err <= 1'b0;
    end else begin
      r_out_vld <= 1'b0;
      r_out_err <= 1'b0;
      if (w_wr) r_cnt <= r_cnt + 5'd1;
      case (r_state)
        S_IDLE: begin
          if (w_wr) begin
            r_state <= S_LOAD;
            r_mode  <= w_mode_in;
            r_det   <= '0;
            r_term  <= '0;
          end
        end
        S_LOAD: begin
          if (w_iss) begin
            if (w_last) begin
              r_term <= '0;
              r_det  <= r_det + 4'd1;
            end else begin
              r_term <= r_term + 2'd1;
            end
          end
          if (r_mode == M_ILL) begin
            if (w_wr && r_cnt == 5'(N_ELEM - 1)) begin
              r_state   <= S_OUT;
              r_out_vld <= 1'b1;
              r_out_err <= 1'b1;
            end
          end else if (w_done) begin
            r_state <= S_DRAIN;
            r_dcnt  <= '0;
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DW'(PIPE_LAT - 1)) begin
            r_state   <= S_OUT;
            r_out_vld <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_OUT: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE) || bus.in_valid;
  assign bus.wr_en     = w_wr;
  assign bus.wr_addr   = r_cnt[3:0];
  assign bus.iss_valid = w_iss;
  assign bus.iss_mode  = w_iss ? r_mode : 2'd0;
  assign bus.iss_det   = w_iss ? r_det : 4'd0;
  assign bus.iss_term  = w_iss ? r_term : 2'd0;
  assign bus.iss_last  = w_last;
  assign bus.out_valid = r_out_vld;
  assign bus.out_err   = r_out_err;
endmodule

// File: tb/tb_mdc_sched_ctrl.sv
// Self-checking bench for mdc_sched_ctrl: directed cases plus randomized matrices checked
// cycle by cycle against a schedule computed from the operand-availability rules.
`timescale 1ns/1ps
module tb_mdc_sched_ctrl;
  import mdc_pkg::*;

  localparam int PIPE_LAT = 3;
  localparam int MAXC     = 160;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdc_sched_ctrl_if bus();
  mdc_sched_ctrl #(.PIPE_LAT(PIPE_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [MODE_W-1:0] mword(input logic [4:0] code, input logic [8:0] mask);
`ifdef MDC_HAMMING_EN
    logic [8:0] p;
    p    = '0;
    p[2] = code[0]; p[4] = code[1]; p[5] = code[2]; p[6] = code[3]; p[8] = code[4];
    p[0] = p[2] ^ p[4] ^ p[6] ^ p[8];
    p[1] = p[2] ^ p[5] ^ p[6];
    p[3] = p[4] ^ p[5] ^ p[6];
    p[7] = p[8];
    return p ^ mask;
`else
    return code | 5'(mask & 9'd0);
`endif
  endfunction

  function automatic int thr_of(input int m, input int k);
    if (m == 0) return 4 * (k / 3) + (k % 3) + 6;
    if (m == 1) return 4 * (k / 2) + (k % 2) + 11;
    return 16;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_mode  = MODE_W'($urandom);
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);
      chk("idle_iss", bus.iss_valid, 0);
      chk("idle_out", bus.out_valid, 0);
    end
  endtask

  // gapsel: 0 back-to-back, 1 hole at cycles 8-9, 2 random holes.
  task automatic run_matrix(input logic [4:0] code, input int gapsel, input bit noise,
                            input logic [8:0] mask, input bit force_ill);
    int  ecyc[16];
    bit  vin[MAXC];
    int  eidx[MAXC];
    int  cnt[MAXC];
    bit  ev[MAXC];
    int  edet[MAXC];
    int  eterm[MAXC];
    bit  elast[MAXC];
    int  m, nd, nt, c, s, nxt, out_c;
    bit  legal;
    logic [MODE_W-1:0] w;

    legal = 1'b1;
    case (code)
      5'b00100: begin m = 0; nd = 9; nt = 1; end
      5'b00110: begin m = 1; nd = 4; nt = 3; end
      5'b10110: begin m = 2; nd = 1; nt = 4; end
      default:  begin m = 3; nd = 0; nt = 0; legal = 1'b0; end
    endcase
    if (force_ill) legal = 1'b0;

    for (int i = 0; i < MAXC; i++) begin
      vin[i] = 0; eidx[i] = 0; ev[i] = 0; edet[i] = 0; eterm[i] = 0; elast[i] = 0;
    end
    c = 0;
    for (int e = 0; e < 16; e++) begin
      if (gapsel == 0)      ecyc[e] = e;
      else if (gapsel == 1) ecyc[e] = (e < 8) ? e : e + 2;
      else begin
        ecyc[e] = c;
        c += 1 + (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      vin[ecyc[e]]  = 1;
      eidx[ecyc[e]] = e;
    end
    for (int x = 0; x < MAXC; x++) begin
      cnt[x] = 0;
      for (int e = 0; e < 16; e++) if (ecyc[e] < x) cnt[x]++;
    end

    if (legal) begin
      nxt = 0;
      for (int k = 0; k < nd; k++) begin
        s = nxt;
        while (cnt[s] < thr_of(m, k)) s++;
        for (int j = 0; j < nt; j++) begin
          ev[s+j] = 1; edet[s+j] = k; eterm[s+j] = j; elast[s+j] = (j == nt - 1);
        end
        nxt = s + nt;
      end
      out_c = nxt - 1 + PIPE_LAT + 1;
    end else begin
      out_c = ecyc[15] + 1;
    end

    w = mword(code, mask);
    for (c = 0; c <= out_c; c++) begin
      @(posedge clk); #1;
      if (vin[c]) begin
        bus.in_valid = 1'b1;
        bus.in_mode  = (eidx[c] == 0) ? w : MODE_W'($urandom);
      end else begin
        bus.in_valid = noise && (c > ecyc[15]) && ($urandom_range(0, 2) == 0);
        bus.in_mode  = MODE_W'($urandom);
      end
      @(negedge clk);
      chk($sformatf("busy@%0d", c), bus.busy, 1);
      chk($sformatf("wr_en@%0d", c), bus.wr_en, vin[c]);
      if (vin[c]) chk($sformatf("wr_addr@%0d", c), bus.wr_addr, eidx[c]);
      chk($sformatf("iss_valid@%0d", c), bus.iss_valid, ev[c]);
      if (ev[c]) begin
        chk($sformatf("iss_mode@%0d", c), bus.iss_mode, m);
        chk($sformatf("iss_det@%0d", c), bus.iss_det, edet[c]);
        chk($sformatf("iss_term@%0d", c), bus.iss_term, eterm[c]);
        chk($sformatf("iss_last@%0d", c), bus.iss_last, elast[c]);
      end
      chk($sformatf("out_valid@%0d", c), bus.out_valid, (c == out_c));
      chk($sformatf("out_err@%0d", c), bus.out_err, (c == out_c) && !legal);
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_iss"}, {bus.iss_valid, bus.iss_mode, bus.iss_det, bus.iss_term, bus.iss_last}, 0);
    chk({tag, "_out"}, {bus.out_valid, bus.out_err}, 0);
  endtask

  initial begin
    logic [4:0] code;
    int         pick;
    logic [8:0] mask;

    bus.in_valid = 1'b0;
    bus.in_mode  = '0;
    #3;
    reset_check("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(1);

    run_matrix(MODE_2X2, 0, 0, 9'd0, 0);
    run_matrix(MODE_3X3, 0, 0, 9'd0, 0);
    run_matrix(MODE_4X4, 0, 0, 9'd0, 0);
    idle_cycles(1);
    run_matrix(MODE_2X2, 1, 0, 9'd0, 0);
    run_matrix(5'b11111, 0, 0, 9'd0, 0);
    run_matrix(MODE_3X3, 0, 1, 9'd0, 0);
`ifdef MDC_HAMMING_EN
    run_matrix(MODE_3X3, 0, 1, 9'd1 << $urandom_range(0, 8), 0);
    run_matrix(MODE_4X4, 0, 0, 9'b010000010, 1);
`endif
    idle_cycles(2);

    // Reset in the middle of a 4x4 load.
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c < 10) begin
        bus.in_valid = 1'b1;
        bus.in_mode  = mword(MODE_4X4, 9'd0);
      end else begin
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
      end
    end
    #1;
    reset_check("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(1);
    run_matrix(MODE_4X4, 0, 0, 9'd0, 0);

    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 3);
      if (pick == 0)      code = MODE_2X2;
      else if (pick == 1) code = MODE_3X3;
      else if (pick == 2) code = MODE_4X4;
      else begin
        code = 5'($urandom);
        while (code == MODE_2X2 || code == MODE_3X3 || code == MODE_4X4) code = 5'($urandom);
      end
      pick = $urandom_range(0, 9);
      mask = (pick < 9) ? (9'd1 << pick) : 9'd0;
      run_matrix(code, 2, 1'($urandom_range(0, 1)), mask, 0);
      idle_cycles($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
